operand_bypass_stage: RTL and testbench
=======================================

// Module: operand_bypass_stage
// PURPOSE
//  Registered ID->EX operand stage with generalised ASEL/BSEL selection plus data
//  forwarding from NUM_FWD in-flight writers and load-use stall detection.
//  Sits between decode/regfile read and the ALU; supplies forwarded ALU operands A/B
//  and the store-data value through a valid/ready pipeline register.
// PARAMETERS
//  XLEN     64  datapath width
//  NUM_FWD  3   forwarding sources; index 0 = youngest (EX), highest = oldest (WB)
//  REG_AW   5   register index width
// PORTS
//  clk            in   1              core clock
//  rstn           in   1              synchronous reset, active low
//  flush          in   1              kill in-flight entry (branch redirect)
//  in_valid       in   1              decode offers an instruction
//  in_ready       out  1              stage accepts this cycle
//  in_pc          in   XLEN           instruction PC
//  in_imm         in   XLEN           decoded immediate
//  in_rs1_idx     in   REG_AW         rs1 index
//  in_rs2_idx     in   REG_AW         rs2 index
//  in_rs1_val     in   XLEN           regfile rs1 read data
//  in_rs2_val     in   XLEN           regfile rs2 read data
//  in_asel        in   alu_asel_op_enum  operand A select (CorePack)
//  in_bsel        in   alu_bsel_op_enum  operand B select (CorePack)
//  in_use_rs2     in   1              rs2 needed as store data
//  fwd_valid      in   NUM_FWD        source i holds a register write
//  fwd_rd         in   NUM_FWD*REG_AW destination index per source
//  fwd_data       in   NUM_FWD*XLEN   write data per source
//  fwd_data_rdy   in   NUM_FWD        data final (0 = load result still pending)
//  out_valid      out  1              operands valid toward EX
//  out_ready      in   1              EX accepts
//  out_a          out  XLEN           ALU operand A
//  out_b          out  XLEN           ALU operand B
//  out_store      out  XLEN           forwarded rs2 for stores
//  out_pc         out  XLEN           PC carried with operands
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): out_valid=0, out_a/out_b/out_store/out_pc=0.
//  - Forward pick per operand: lowest index i with fwd_valid[i] && fwd_rd[i]==idx
//    && idx!=0; none -> regfile value. Index 0 (x0) always reads 0, never forwarded.
//  - Operand A: ASEL_REG->fwd rs1; ASEL_PC->in_pc; ASEL0/ASEL3/other->0.
//    Operand B: BSEL_REG->fwd rs2; BSEL_IMM->in_imm; BSEL0/BSEL3/other->0.
//    Store data: fwd rs2 (independent of in_bsel).
//  - Hazard: selected source for a USED operand has fwd_data_rdy=0.
//    rs1 used iff asel==ASEL_REG; rs2 used iff bsel==BSEL_REG or in_use_rs2.
//    Only the winning (youngest) match counts; an older pending match is ignored.
//  - in_ready = !hazard && (!out_valid || out_ready) && !flush. Combinational.
//  - Accept (in_valid && in_ready): latch operands, out_valid=1 next cycle. Latency 1.
//  - out_valid && !out_ready: all out_* held stable; forwarding re-evaluation is
//    not performed on held data (producers stall upstream of writeback).
//  - out_valid && out_ready && no accept: out_valid=0 next cycle.
//  - Back-to-back: accept and drain in same cycle -> new data, out_valid stays 1.
//  - flush: out_valid=0 next cycle; overrides simultaneous accept and drain.
//  - reset mid-transfer: wins over flush/accept; entry is lost.
//  - Full-width XLEN; no extension or truncation in this stage.
// STRUCTURE
//  - CorePack: reuse alu_asel_op_enum/alu_bsel_op_enum; add fwd_src_t
//    (struct: valid, rd, data, data_rdy) for a packed-array form of the fwd_* ports.
//  - Sub-module fwd_select #(XLEN,NUM_FWD,REG_AW): combinational priority pick,
//    outputs {value, pending}; instantiated twice (rs1, rs2).
//  - Top: operand muxes, hazard/ready logic, one pipeline register.
// TESTING
//  1 Reset: rstn=0 two cycles -> out_valid=0, out_a=out_b=out_store=out_pc=0.
//  2 No fwd: rs1=5 val=0x10, imm=0x4, ASEL_REG/BSEL_IMM -> next cycle out_a=0x10, out_b=0x4.
//  3 Priority: fwd[0] rd=5 data=0xAA, fwd[2] rd=5 data=0xCC, rdy=1 -> out_a=0xAA.
//  4 x0: rs1=0, fwd[0] rd=0 data=0xFF -> out_a=0; ASEL_PC pc=0x1000 -> out_a=0x1000.
//  5 Load-use: fwd[0] rd=7 rdy=0, rs2=7, BSEL_REG -> in_ready=0, out_valid=0;
//    rdy=1 data=0x55 next cycle -> accepted, out_b=0x55. Same with BSEL_IMM and
//    in_use_rs2=0 -> no stall.
//  6 Backpressure/flush: out_ready=0 three cycles -> outputs stable, in_ready=0;
//    flush with in_valid=1 -> out_valid=0 next cycle, nothing captured.

Source files
------------

// File: rtl/operand_bypass_stage_pkg.sv
// Shared types for the ID->EX operand bypass stage: operand-select encodings and
// a structured view of one forwarding source.
package operand_bypass_stage_pkg;

    localparam int unsigned XlenDefault   = 64;
    localparam int unsigned NumFwdDefault = 3;
    localparam int unsigned RegAwDefault  = 5;

    // Operand A select; ASEL0 and ASEL3 both yield zero.
    typedef enum logic [1:0] {
        ASEL0    = 2'd0,
        ASEL_REG = 2'd1,
        ASEL_PC  = 2'd2,
        ASEL3    = 2'd3
    } alu_asel_op_enum;

    // Operand B select; BSEL0 and BSEL3 both yield zero.
    typedef enum logic [1:0] {
        BSEL0    = 2'd0,
        BSEL_REG = 2'd1,
        BSEL_IMM = 2'd2,
        BSEL3    = 2'd3
    } alu_bsel_op_enum;

    // One in-flight register writer as seen by the bypass network.
    typedef struct packed {
        logic                    valid;
        logic [RegAwDefault-1:0] rd;
        logic [XlenDefault-1:0]  data;
        logic                    data_rdy;
    } fwd_src_t;

    // True when an operand select actually consumes the register value.
    function automatic logic asel_uses_rs1(input alu_asel_op_enum asel);
        return asel == ASEL_REG;
    endfunction

    function automatic logic bsel_uses_rs2(input alu_bsel_op_enum bsel, input logic use_rs2);
        return (bsel == BSEL_REG) || use_rs2;
    endfunction

endpackage

// File: rtl/operand_bypass_stage_fwd_select.sv
// Priority pick of one register operand from the in-flight writers. Source 0 is the
// youngest and wins; x0 always reads zero and is never forwarded or pending.
module fwd_select #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NUM_FWD = 3,
    parameter int unsigned REG_AW  = 5
) (
    input  logic [REG_AW-1:0]         idx_i,
    input  logic [XLEN-1:0]           rf_val_i,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
    input  logic [NUM_FWD-1:0]        fwd_data_rdy_i,
    output logic [XLEN-1:0]           value_o,
    output logic                      pending_o
);

    // Walk oldest to youngest so the youngest match overwrites and wins.
    always_comb begin
        value_o   = rf_val_i;
        pending_o = 1'b0;
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (fwd_valid_i[i] && (fwd_rd_i[i*REG_AW +: REG_AW] == idx_i)) begin
                value_o   = fwd_data_i[i*XLEN +: XLEN];
                pending_o = ~fwd_data_rdy_i[i];
            end
        end
        if (idx_i == '0) begin
            value_o   = '0;
            pending_o = 1'b0;
        end
    end

endmodule

// File: rtl/operand_bypass_stage.sv
// Registered ID->EX operand stage: forwards rs1/rs2 from in-flight writers, builds
// ALU operands A/B and store data, stalls on load-use, and holds one entry in a
// valid/ready pipeline register.
module operand_bypass_stage
    import operand_bypass_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NUM_FWD = 3,
    parameter int unsigned REG_AW  = 5
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [XLEN-1:0]           in_pc_i,
    input  logic [XLEN-1:0]           in_imm_i,
    input  logic [REG_AW-1:0]         in_rs1_idx_i,
    input  logic [REG_AW-1:0]         in_rs2_idx_i,
    input  logic [XLEN-1:0]           in_rs1_val_i,
    input  logic [XLEN-1:0]           in_rs2_val_i,
    input  alu_asel_op_enum           in_asel_i,
    input  alu_bsel_op_enum           in_bsel_i,
    input  logic                      in_use_rs2_i,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
    input  logic [NUM_FWD-1:0]        fwd_data_rdy_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [XLEN-1:0]           out_a_o,
    output logic [XLEN-1:0]           out_b_o,
    output logic [XLEN-1:0]           out_store_o,
    output logic [XLEN-1:0]           out_pc_o
);

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            rs1_pending, rs2_pending;
    logic [XLEN-1:0] op_a, op_b;
    logic            hazard, accept;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] store_q, store_d;
    logic [XLEN-1:0] pc_q, pc_d;

    fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW)
    ) u_fwd_rs1 (
        .idx_i          (in_rs1_idx_i),
        .rf_val_i       (in_rs1_val_i),
        .fwd_valid_i    (fwd_valid_i),
        .fwd_rd_i       (fwd_rd_i),
        .fwd_data_i     (fwd_data_i),
        .fwd_data_rdy_i (fwd_data_rdy_i),
        .value_o        (rs1_fwd),
        .pending_o      (rs1_pending)
    );

    fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW)
    ) u_fwd_rs2 (
        .idx_i          (in_rs2_idx_i),
        .rf_val_i       (in_rs2_val_i),
        .fwd_valid_i    (fwd_valid_i),
        .fwd_rd_i       (fwd_rd_i),
        .fwd_data_i     (fwd_data_i),
        .fwd_data_rdy_i (fwd_data_rdy_i),
        .value_o        (rs2_fwd),
        .pending_o      (rs2_pending)
    );

    // Operand muxes; unused encodings feed zero.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (in_asel_i)
            ASEL_REG: op_a = rs1_fwd;
            ASEL_PC:  op_a = in_pc_i;
            default:  op_a = '0;
        endcase
        case (in_bsel_i)
            BSEL_REG: op_b = rs2_fwd;
            BSEL_IMM: op_b = in_imm_i;
            default:  op_b = '0;
        endcase
    end

    // Stall only when an operand that is actually consumed waits on a pending load.
    always_comb begin
        hazard = (asel_uses_rs1(in_asel_i) && rs1_pending) ||
                 (bsel_uses_rs2(in_bsel_i, in_use_rs2_i) && rs2_pending);
        in_ready_o = ~hazard && (~valid_q || out_ready_i) && ~flush_i;
        accept     = in_valid_i && in_ready_o;
    end

    // Next state of the pipeline register; flush kills the entry but keeps old data.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        store_d = store_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            a_d     = op_a;
            b_d     = op_b;
            store_d = rs2_fwd;
            pc_d    = in_pc_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            store_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            store_q <= store_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_a_o     = a_q;
    assign out_b_o     = b_q;
    assign out_store_o = store_q;
    assign out_pc_o    = pc_q;

endmodule

// File: tb/tb_operand_bypass_stage.sv
// Self-checking bench for operand_bypass_stage: directed scenarios followed by a
// randomized run against a behavioural model of the stage.
module tb_operand_bypass_stage;
    import operand_bypass_stage_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NF   = 3;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rstn, flush, in_valid, in_ready, in_use_rs2;
    logic [XLEN-1:0] in_pc, in_imm, in_rs1_val, in_rs2_val;
    logic [AW-1:0]   in_rs1_idx, in_rs2_idx;
    alu_asel_op_enum in_asel;
    alu_bsel_op_enum in_bsel;
    logic [NF-1:0]      fwd_valid, fwd_data_rdy;
    logic [NF*AW-1:0]   fwd_rd;
    logic [NF*XLEN-1:0] fwd_data;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_a, out_b, out_store, out_pc;

    fwd_src_t fwd_m [NF];

    int n_cmp = 0;
    int n_err = 0;

    // Model state of the single pipeline entry.
    logic            m_valid;
    logic [XLEN-1:0] m_a, m_b, m_st, m_pc;

    always #5 clk = ~clk;

    operand_bypass_stage #(.XLEN(XLEN), .NUM_FWD(NF), .REG_AW(AW)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_pc_i        (in_pc),
        .in_imm_i       (in_imm),
        .in_rs1_idx_i   (in_rs1_idx),
        .in_rs2_idx_i   (in_rs2_idx),
        .in_rs1_val_i   (in_rs1_val),
        .in_rs2_val_i   (in_rs2_val),
        .in_asel_i      (in_asel),
        .in_bsel_i      (in_bsel),
        .in_use_rs2_i   (in_use_rs2),
        .fwd_valid_i    (fwd_valid),
        .fwd_rd_i       (fwd_rd),
        .fwd_data_i     (fwd_data),
        .fwd_data_rdy_i (fwd_data_rdy),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_a_o        (out_a),
        .out_b_o        (out_b),
        .out_store_o    (out_store),
        .out_pc_o       (out_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fwd();
        for (int i = 0; i < int'(NF); i++) begin
            fwd_valid[i]             = fwd_m[i].valid;
            fwd_rd[i*AW +: AW]       = fwd_m[i].rd;
            fwd_data[i*XLEN +: XLEN] = fwd_m[i].data;
            fwd_data_rdy[i]          = fwd_m[i].data_rdy;
        end
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; in_use_rs2 = 0; out_ready = 1;
        in_pc = '0; in_imm = '0; in_rs1_val = '0; in_rs2_val = '0;
        in_rs1_idx = '0; in_rs2_idx = '0; in_asel = ASEL0; in_bsel = BSEL0;
        for (int i = 0; i < int'(NF); i++) fwd_m[i] = '0;
        drive_fwd();
    endtask

    // Reference: youngest matching writer supplies the value; x0 is hard zero.
    function automatic logic [XLEN-1:0] model_pick(input logic [AW-1:0] idx,
                                                   input logic [XLEN-1:0] rf,
                                                   output logic pend);
        pend = 1'b0;
        if (idx == 0) return '0;
        for (int i = 0; i < int'(NF); i++) begin
            if (fwd_m[i].valid && fwd_m[i].rd == idx) begin
                pend = !fwd_m[i].data_rdy;
                return fwd_m[i].data;
            end
        end
        return rf;
    endfunction

    task automatic test_reset();
        clear_inputs();
        rstn = 0; in_valid = 1; in_rs1_val = 64'hDEAD; in_asel = ASEL_REG; in_rs1_idx = 5'd3;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++; if ({out_a, out_b, out_store, out_pc} !== '0) begin n_err++;
            $display("FAIL reset_data got %h %h %h %h want 0", out_a, out_b, out_store, out_pc); end
        rstn = 1;
        clear_inputs();
        tick();
    endtask

    task automatic test_no_fwd();
        clear_inputs();
        in_valid = 1; in_rs1_idx = 5'd5; in_rs1_val = 64'h10; in_imm = 64'h4;
        in_rs2_idx = 5'd3; in_rs2_val = 64'h33; in_pc = 64'h200;
        in_asel = ASEL_REG; in_bsel = BSEL_IMM;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL nofwd_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b1 || out_a !== 64'h10 || out_b !== 64'h4) begin n_err++;
            $display("FAIL nofwd_ops got v=%0b a=%h b=%h want v=1 a=10 b=4", out_valid, out_a, out_b); end
        n_cmp++; if (out_store !== 64'h33 || out_pc !== 64'h200) begin n_err++;
            $display("FAIL nofwd_st_pc got st=%h pc=%h want 33 200", out_store, out_pc); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL nofwd_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_priority();
        clear_inputs();
        fwd_m[0] = '{valid: 1, rd: 5'd5, data: 64'hAA, data_rdy: 1};
        fwd_m[1] = '{valid: 1, rd: 5'd5, data: 64'hBB, data_rdy: 1};
        fwd_m[2] = '{valid: 1, rd: 5'd9, data: 64'hCC, data_rdy: 1};
        drive_fwd();
        in_valid = 1; in_rs1_idx = 5'd5; in_rs1_val = 64'h1; in_rs2_idx = 5'd9;
        in_rs2_val = 64'h2; in_asel = ASEL_REG; in_bsel = BSEL0; in_use_rs2 = 1;
        tick();
        in_valid = 0;
        n_cmp++; if (out_a !== 64'hAA) begin n_err++;
            $display("FAIL prio_a got %h want aa", out_a); end
        n_cmp++; if (out_store !== 64'hCC || out_b !== 64'h0) begin n_err++;
            $display("FAIL prio_store got st=%h b=%h want cc 0", out_store, out_b); end
        tick();
    endtask

    task automatic test_x0();
        clear_inputs();
        fwd_m[0] = '{valid: 1, rd: 5'd0, data: 64'hFF, data_rdy: 0};
        drive_fwd();
        in_valid = 1; in_rs1_idx = 5'd0; in_rs1_val = 64'h0; in_asel = ASEL_REG;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL x0_ready got %0b want 1", in_ready); end
        tick();
        n_cmp++; if (out_a !== 64'h0) begin n_err++;
            $display("FAIL x0_a got %h want 0", out_a); end
        in_asel = ASEL_PC; in_pc = 64'h1000;
        tick();
        in_valid = 0;
        n_cmp++; if (out_a !== 64'h1000 || out_pc !== 64'h1000) begin n_err++;
            $display("FAIL x0_pc got a=%h pc=%h want 1000", out_a, out_pc); end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        fwd_m[0] = '{valid: 1, rd: 5'd7, data: 64'h0, data_rdy: 0};
        fwd_m[2] = '{valid: 1, rd: 5'd7, data: 64'h77, data_rdy: 1};
        drive_fwd();
        in_valid = 1; in_rs2_idx = 5'd7; in_rs2_val = 64'h9; in_bsel = BSEL_REG;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL lu_stall got %0b want 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL lu_valid got %0b want 0", out_valid); end
        fwd_m[0].data_rdy = 1; fwd_m[0].data = 64'h55;
        drive_fwd();
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL lu_release got %0b want 1", in_ready); end
        tick();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b1 || out_b !== 64'h55) begin n_err++;
            $display("FAIL lu_b got v=%0b b=%h want 1 55", out_valid, out_b); end
        tick();
        // rs2 not consumed: a pending writer must not stall.
        fwd_m[0].data_rdy = 0; drive_fwd();
        in_valid = 1; in_bsel = BSEL_IMM; in_use_rs2 = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL lu_unused got %0b want 1", in_ready); end
        // Older pending writer hidden behind a ready younger one.
        fwd_m[0].data_rdy = 1; fwd_m[1] = '{valid: 1, rd: 5'd7, data: 64'h0, data_rdy: 0};
        drive_fwd();
        in_bsel = BSEL_REG;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL lu_older got %0b want 1", in_ready); end
        in_valid = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        in_valid = 1; in_asel = ASEL_PC; in_pc = 64'hA0;
        tick();
        in_pc = 64'hB0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL b2b_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b1 || out_a !== 64'hB0) begin n_err++;
            $display("FAIL b2b_data got v=%0b a=%h want 1 b0", out_valid, out_a); end
        tick();
    endtask

    task automatic test_backpressure_flush();
        clear_inputs();
        in_valid = 1; in_asel = ASEL_PC; in_pc = 64'h111; in_imm = 64'h5; in_bsel = BSEL_IMM;
        tick();
        out_ready = 0; in_pc = 64'h222; in_imm = 64'h6;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++;
                $display("FAIL bp_ready[%0d] got %0b want 0", k, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_a !== 64'h111 || out_b !== 64'h5) begin n_err++;
                $display("FAIL bp_hold[%0d] got v=%0b a=%h b=%h want 1 111 5", k, out_valid,
                         out_a, out_b); end
        end
        out_ready = 1; flush = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL flush_ready got %0b want 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_a !== 64'h111) begin n_err++;
            $display("FAIL flush_kill got v=%0b a=%h want 0 111", out_valid, out_a); end
        // Reset beats a simultaneous accept.
        flush = 0;
        tick();
        rstn = 0;
        tick();
        rstn = 1; in_valid = 0;
        n_cmp++; if (out_valid !== 1'b0 || out_a !== 64'h0 || out_pc !== 64'h0) begin n_err++;
            $display("FAIL rst_mid got v=%0b a=%h pc=%h want 0", out_valid, out_a, out_pc); end
        tick();
    endtask

    task automatic test_random();
        logic            p1, p2, exp_ready, hz;
        logic [XLEN-1:0] v1, v2, ea, eb;
        clear_inputs();
        rstn = 0; tick(); rstn = 1;
        m_valid = 0; m_a = '0; m_b = '0; m_st = '0; m_pc = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < int'(NF); i++) begin
                fwd_m[i].valid    = ($urandom_range(0, 3) != 0);
                fwd_m[i].rd       = 5'($urandom_range(0, 7));
                fwd_m[i].data     = {$urandom, $urandom};
                fwd_m[i].data_rdy = ($urandom_range(0, 3) != 0);
            end
            drive_fwd();
            in_valid   = $urandom_range(0, 1);
            flush      = ($urandom_range(0, 9) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_rs1_idx = 5'($urandom_range(0, 7));
            in_rs2_idx = 5'($urandom_range(0, 7));
            in_rs1_val = {$urandom, $urandom};
            in_rs2_val = {$urandom, $urandom};
            in_pc      = {$urandom, $urandom};
            in_imm     = {$urandom, $urandom};
            in_asel    = alu_asel_op_enum'(2'($urandom_range(0, 3)));
            in_bsel    = alu_bsel_op_enum'(2'($urandom_range(0, 3)));
            in_use_rs2 = $urandom_range(0, 1);
            v1 = model_pick(in_rs1_idx, in_rs1_val, p1);
            v2 = model_pick(in_rs2_idx, in_rs2_val, p2);
            ea = (in_asel == ASEL_REG) ? v1 : (in_asel == ASEL_PC) ? in_pc : '0;
            eb = (in_bsel == BSEL_REG) ? v2 : (in_bsel == BSEL_IMM) ? in_imm : '0;
            hz = (in_asel == ASEL_REG && p1) || ((in_bsel == BSEL_REG || in_use_rs2) && p2);
            exp_ready = !hz && (!m_valid || out_ready) && !flush;
            #1;
            n_cmp++; if (in_ready !== exp_ready) begin n_err++;
                $display("FAIL rnd_ready[%0d] got %0b want %0b", n, in_ready, exp_ready); end
            if (flush) m_valid = 0;
            else if (in_valid && exp_ready) begin
                m_valid = 1; m_a = ea; m_b = eb; m_st = v2; m_pc = in_pc;
            end else if (out_ready) m_valid = 0;
            tick();
            n_cmp++;
            if (out_valid !== m_valid || out_a !== m_a || out_b !== m_b ||
                out_store !== m_st || out_pc !== m_pc) begin
                n_err++;
                $display("FAIL rnd_out[%0d] got v=%0b a=%h b=%h st=%h pc=%h want v=%0b a=%h b=%h st=%h pc=%h",
                         n, out_valid, out_a, out_b, out_store, out_pc,
                         m_valid, m_a, m_b, m_st, m_pc);
            end
        end
    endtask

    initial begin
        rstn = 0;
        clear_inputs();
        #2;
        test_reset();
        test_no_fwd();
        test_priority();
        test_x0();
        test_load_use();
        test_back_to_back();
        test_backpressure_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
